// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Bit-serial sequencer driving an external 1-bit ALU slice.
//               Accepts one operation, walks the operand bits LSB first
//               through the slice (one bit per clock), and presents the
//               assembled result with carry, zero and signed-overflow flags
//               under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic [1:0]       op_sel,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_b_inv,
    output logic             slice_c_in,
    output logic [1:0]       slice_operation,
    input  logic             slice_result,
    input  logic             slice_carry_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]    c_S_IDLE = 2'd0;
    localparam logic [1:0]    c_S_RUN  = 2'd1;
    localparam logic [1:0]    c_S_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST   = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [1:0]       r_sel;
    logic             r_carry;
    logic [WIDTH-1:0] r_data;
    logic             r_res_carry;
    logic             r_ovf;

    logic w_idle;
    logic w_run;
    logic w_done;
    logic w_accept;
    logic w_last;

    assign w_idle   = (r_state == c_S_IDLE);
    assign w_run    = (r_state == c_S_RUN);
    assign w_done   = (r_state == c_S_DONE);
    assign w_accept = start_valid && w_idle;
    assign w_last   = w_run && (r_cnt == c_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a single pass over all bits, then hold until consumed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept)  w_state_next = c_S_RUN;
            c_S_RUN:  if (w_last)    w_state_next = c_S_DONE;
            c_S_DONE: if (res_ready) w_state_next = c_S_IDLE;
            default:                 w_state_next = c_S_IDLE;
        endcase
    end

    // Slice drive: only active while stepping through bits, quiet otherwise.
    always_comb begin
        slice_a         = 1'b0;
        slice_b         = 1'b0;
        slice_b_inv     = 1'b0;
        slice_c_in      = 1'b0;
        slice_operation = 2'b00;
        if (w_run) begin
            slice_a         = r_a[r_cnt];
            slice_b         = r_b[r_cnt];
            slice_b_inv     = r_sub;
            // Bit 0 takes the subtract carry-in; later bits chain the carry.
            slice_c_in      = (r_cnt == '0) ? r_sub : r_carry;
            slice_operation = r_sel;
        end
    end

    // Operand capture, bit counter and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_sel       <= 2'b00;
            r_carry     <= 1'b0;
            r_data      <= '0;
            r_res_carry <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= '0;
            r_a         <= op_a;
            r_b         <= op_b;
            r_sub       <= op_sub;
            r_sel       <= op_sel;
            r_carry     <= 1'b0;
            r_data      <= '0;
            r_res_carry <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_run) begin
            r_data[r_cnt] <= slice_result;
            r_carry       <= slice_carry_out;
            if (w_last) begin
                r_cnt       <= '0;
                r_res_carry <= slice_carry_out;
                // Signed overflow: carry into MSB differs from carry out of it.
                r_ovf       <= slice_c_in ^ slice_carry_out;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Results are only exposed in DONE so a partial value is never visible.
    assign start_ready  = w_idle;
    assign res_valid    = w_done;
    assign res_data     = w_done ? r_data : '0;
    assign res_carry    = w_done & r_res_carry;
    assign res_overflow = w_done & r_ovf;
    assign res_zero     = w_done & (r_data == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_seq
// Description : Directed self-checking bench for alu_serial_seq with a
//               behavioural 1-bit adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [1:0]       op_sel;
    logic             slice_a;
    logic             slice_b;
    logic             slice_b_inv;
    logic             slice_c_in;
    logic [1:0]       slice_operation;
    logic             slice_result;
    logic             slice_carry_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;
    logic             res_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .op_sub          (op_sub),
        .op_sel          (op_sel),
        .slice_a         (slice_a),
        .slice_b         (slice_b),
        .slice_b_inv     (slice_b_inv),
        .slice_c_in      (slice_c_in),
        .slice_operation (slice_operation),
        .slice_result    (slice_result),
        .slice_carry_out (slice_carry_out),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_carry       (res_carry),
        .res_zero        (res_zero),
        .res_overflow    (res_overflow)
    );

    // Behavioural 1-bit slice: full adder for op 00, result 0 otherwise.
    logic w_bb;
    assign w_bb            = slice_b ^ slice_b_inv;
    assign slice_result    = (slice_operation == 2'b00) ? (slice_a ^ w_bb ^ slice_c_in) : 1'b0;
    assign slice_carry_out = (slice_a & w_bb) | (slice_a & slice_c_in) | (w_bb & slice_c_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation, scramble inputs after acceptance, wait for valid.
    // Returns latency in clocks (0 on timeout) and the first-bit slice drive.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, output int lat, output logic [5:0] first);
        lat = 0;
        op_a = a; op_b = b; op_sub = sub; op_sel = 2'b00; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        first = {slice_a, slice_b, slice_b_inv, slice_c_in, slice_operation};
        op_a = ~a; op_b = ~b; op_sub = ~sub; op_sel = 2'b11;
        for (int n = 1; n <= WIDTH + 8; n++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0; op_sel = 2'b00;
        #2;
        n_checks++;
        if ({start_ready, res_valid, res_data, res_carry, res_zero, res_overflow} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h c=%b z=%b o=%b, want rdy=1 vld=0 data=0 flags=0",
                     start_ready, res_valid, res_data, res_carry, res_zero, res_overflow);
        end
        n_checks++;
        if ({slice_a, slice_b, slice_b_inv, slice_c_in, slice_operation} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_slice: got %b want 000000",
                     {slice_a, slice_b, slice_b_inv, slice_c_in, slice_operation});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // res_ready while idle must not disturb anything.
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_res_ready: got rdy=%b vld=%b want rdy=1 vld=0", start_ready, res_valid);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [5:0] first;
        run_op(32'd5, 32'd3, 1'b0, lat, first);
        n_checks++;
        if (lat !== WIDTH) begin
            n_fail++;
            $display("FAIL add_latency: got %0d want %0d", lat, WIDTH);
        end
        n_checks++;
        if (first !== 6'b110000) begin
            n_fail++;
            $display("FAIL add_first_bit_slice: got %b want 110000", first);
        end
        n_checks++;
        if ({res_data, res_carry, res_zero, res_overflow} !== {32'h00000008, 3'b000}) begin
            n_fail++;
            $display("FAIL add_5_3: got data=%h c=%b z=%b o=%b want 00000008 c=0 z=0 o=0",
                     res_data, res_carry, res_zero, res_overflow);
        end
        n_checks++;
        if (start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_not_ready: got start_ready=%b want 0", start_ready);
        end
        release_result();
        n_checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
            n_fail++;
            $display("FAIL back_to_idle: got rdy=%b vld=%b data=%h want rdy=1 vld=0 data=0",
                     start_ready, res_valid, res_data);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [5:0] first;
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, first);
        n_checks++;
        if (lat !== WIDTH || {res_data, res_carry, res_zero, res_overflow} !== {32'h80000000, 3'b001}) begin
            n_fail++;
            $display("FAIL add_signed_ovf: got lat=%0d data=%h c=%b z=%b o=%b want lat=32 data=80000000 c=0 z=0 o=1",
                     lat, res_data, res_carry, res_zero, res_overflow);
        end
        release_result();
    endtask

    task automatic test_wrap();
        int lat;
        logic [5:0] first;
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, first);
        n_checks++;
        if (lat !== WIDTH || {res_data, res_carry, res_zero, res_overflow} !== {32'h00000000, 3'b110}) begin
            n_fail++;
            $display("FAIL add_wrap: got lat=%0d data=%h c=%b z=%b o=%b want lat=32 data=0 c=1 z=1 o=0",
                     lat, res_data, res_carry, res_zero, res_overflow);
        end
        release_result();
    endtask

    task automatic test_sub();
        int lat;
        logic [5:0] first;
        run_op(32'd5, 32'd5, 1'b1, lat, first);
        n_checks++;
        if (first !== 6'b111100) begin
            n_fail++;
            $display("FAIL sub_first_bit_slice: got %b want 111100", first);
        end
        n_checks++;
        if (lat !== WIDTH || {res_data, res_carry, res_zero, res_overflow} !== {32'h00000000, 3'b110}) begin
            n_fail++;
            $display("FAIL sub_5_5: got lat=%0d data=%h c=%b z=%b o=%b want lat=32 data=0 c=1 z=1 o=0",
                     lat, res_data, res_carry, res_zero, res_overflow);
        end
        release_result();
        run_op(32'd3, 32'd5, 1'b1, lat, first);
        n_checks++;
        if (lat !== WIDTH || {res_data, res_carry, res_zero, res_overflow} !== {32'hFFFFFFFE, 3'b000}) begin
            n_fail++;
            $display("FAIL sub_3_5: got lat=%0d data=%h c=%b z=%b o=%b want lat=32 data=fffffffe c=0 z=0 o=0",
                     lat, res_data, res_carry, res_zero, res_overflow);
        end
        release_result();
    endtask

    task automatic test_hold();
        int lat;
        logic [5:0] first;
        int bad;
        bad = 0;
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, first);
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op_a = 32'h1111_0000 + i; op_b = 32'h0000_2222 * i; op_sub = i[0];
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || start_ready !== 1'b0 ||
                {res_data, res_carry, res_zero, res_overflow} !== {32'h80000000, 3'b001})
                bad++;
        end
        start_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d unstable cycles, last data=%h vld=%b rdy=%b want 0 unstable (data=80000000)",
                     bad, res_data, res_valid, start_ready);
        end
        release_result();
        n_checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_no_accept: got vld=%b rdy=%b want vld=0 rdy=1", res_valid, start_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [5:0] first;
        op_a = 32'h00000400; op_b = 32'h00000400; op_sub = 1'b0; op_sel = 2'b00;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if ({slice_a, slice_b, slice_b_inv, slice_c_in} !== 4'b1100) begin
            n_fail++;
            $display("FAIL bit10_slice: got a=%b b=%b inv=%b cin=%b want a=1 b=1 inv=0 cin=0",
                     slice_a, slice_b, slice_b_inv, slice_c_in);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({slice_a, slice_b, slice_b_inv, slice_c_in, slice_operation} !== 6'b0 ||
            {res_valid, res_data, res_carry, res_zero, res_overflow} !== 36'h0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_run: got slice=%b vld=%b data=%h c=%b z=%b o=%b rdy=%b want all 0, rdy=1",
                     {slice_a, slice_b, slice_b_inv, slice_c_in, slice_operation},
                     res_valid, res_data, res_carry, res_zero, res_overflow, start_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(32'd1, 32'd1, 1'b0, lat, first);
        n_checks++;
        if (lat !== WIDTH || {res_data, res_carry, res_zero, res_overflow} !== {32'h00000002, 3'b000}) begin
            n_fail++;
            $display("FAIL after_reset_1_1: got lat=%0d data=%h c=%b z=%b o=%b want lat=32 data=00000002 flags=0",
                     lat, res_data, res_carry, res_zero, res_overflow);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_wrap();
        test_sub();
        test_hold();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (>=2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_valid  input  1  request carries a valid operation.
REQ-005 start_ready  output  1  block can accept a request.
REQ-006 op_a  input  WIDTH  operand A.
REQ-007 op_b  input  WIDTH  operand B.
REQ-008 op_sub  input  1  1 = subtract (invert B, carry-in 1); 0 = add.
REQ-009 op_sel  input  2  operation select forwarded to the slice.
REQ-010 slice_a  output  1  A bit to 1-bit ALU slice.
REQ-011 slice_b  output  1  B bit to slice.
REQ-012 slice_b_inv  output  1  B-invert to slice.
REQ-013 slice_c_in  output  1  carry-in to slice.
REQ-014 slice_operation  output  2  operation select to slice.
REQ-015 slice_result  input  1  slice result bit (combinational from slice_* outputs).
REQ-016 slice_carry_out  input  1  slice carry-out (combinational).
REQ-017 res_valid  output  1  result available.
REQ-018 res_ready  input  1  consumer takes result.
REQ-019 res_data  output  WIDTH  assembled result.
REQ-020 res_carry  output  1  carry out of MSB.
REQ-021 res_zero  output  1  res_data == 0.
REQ-022 res_overflow  output  1  signed overflow.

Function
REQ-023 FSM states IDLE, RUN, DONE; IDLE->RUN on start_valid&&start_ready; RUN->DONE after WIDTH RUN cycles; DONE->IDLE on res_ready.
REQ-024 start_ready = 1 only in IDLE; start_valid outside IDLE is ignored, no queuing.
REQ-025 On acceptance: op_a, op_b, op_sub, op_sel captured; later input changes have no effect.
REQ-026 Bit counter 0..WIDTH-1, LSB first; in RUN, slice_a/slice_b = captured bit[counter], slice_b_inv = op_sub, slice_operation = op_sel.
REQ-027 slice_c_in = op_sub when counter = 0, else registered slice_carry_out of previous bit.
REQ-028 Each RUN cycle: res_data[counter] <= slice_result; carry register <= slice_carry_out.
REQ-029 At counter = WIDTH-1: res_carry <= slice_carry_out; res_overflow <= slice_c_in XOR slice_carry_out.
REQ-030 Latency: res_valid rises exactly WIDTH cycles after the accepting edge.
REQ-031 Outside RUN, all slice_* outputs = 0.
REQ-032 res_valid = 1 only in DONE; res_data/res_carry/res_zero/res_overflow stable while res_valid=1 and res_ready=0.
REQ-033 res_zero computed from final res_data; valid whenever res_valid=1.
REQ-034 res_ready while res_valid=0 is ignored; minimum one IDLE cycle between results (no accept in DONE exit cycle).
REQ-035 op_sel values other than 00 pass through; result bits are whatever the slice returns (currently 0), carry/overflow still from slice_carry_out.

Reset
REQ-036 rst_n=0 forces IDLE immediately, counter/shift registers cleared, all outputs 0 except start_ready = 1 (after reset asserted).
REQ-037 Reset during RUN or DONE aborts the operation; no partial result is ever presented.

Verification (WIDTH=32, behavioural 1-bit adder slice)
REQ-038 Add 5+3 -> res_data=0x00000008, carry=0, zero=0, overflow=0, res_valid 32 cycles after accept.
REQ-039 Add 0x7FFFFFFF+0x00000001 -> res_data=0x80000000, overflow=1, carry=0.
REQ-040 Add 0xFFFFFFFF+0x00000001 -> res_data=0, carry=1, zero=1, overflow=0.
REQ-041 Sub 5-5 (op_sub=1) -> res_data=0, zero=1, carry=1; sub 3-5 -> 0xFFFFFFFE, carry=0.
REQ-042 Hold res_ready=0 for 10 cycles in DONE with start_valid=1 and changing operands -> outputs stable, start_ready=0, no new accept.
REQ-043 Assert rst_n=0 at bit 10 of a RUN -> all slice_* and res_* = 0 at once, start_ready=1; new 1+1 afterwards -> 0x00000002.
